text_ram_arbiter: RTL and testbench
===================================

# text_ram_arbiter

Arbitrates single-port text RAM access between the VT100 parser (reads and writes for character output, scrolling and erase) and the display renderer (character fetch for the VGA scan-out). Sits between the parser's RAM request path and the text RAM macro. Parser writes are posted into a small FIFO so the parser rarely stalls. Renderer reads get priority, with an optional anti-starvation guarantee for the parser.

## Interface
Parameters:
- ADDR_W, 12, text RAM address width (80x25 cells fit in 4096).
- DATA_W, 32, cell word width (char code plus fg/bg/attributes).
- FIFO_DEPTH, 4, posted-write FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 8, parser-waiting cycles before a forced parser grant (only with the fairness feature).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- p_req  in  1  parser request valid.
- p_we  in  1  parser request is a write.
- p_addr  in  ADDR_W  parser address.
- p_wdata  in  DATA_W  parser write data.
- p_ack  out  1  parser request accepted this cycle.
- p_rvalid  out  1  parser read data valid.
- p_rdata  out  DATA_W  parser read data.
- r_req  in  1  renderer read request.
- r_addr  in  ADDR_W  renderer address.
- r_ack  out  1  renderer request issued to RAM this cycle.
- r_rvalid  out  1  renderer read data valid.
- r_rdata  out  DATA_W  renderer read data.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0.

## Operation
- Exactly one RAM access per cycle. Sources in priority order: renderer read, FIFO-head write, parser read.
- Parser write: p_ack is combinational and equals `p_req & p_we & !fifo_full & (pstate==P_IDLE)`. On ack the {addr, data} pair is pushed into the FIFO.
  - Full FIFO: p_ack stays 0 and the parser holds the request.
  - A simultaneous push and pop on a full FIFO is not allowed. The push is refused.
- Parser read state machine:
  - P_IDLE: on `p_req & !p_we`, go to P_DRAIN. p_ack=0.
  - P_DRAIN: wait for FIFO empty. This preserves read-after-write order. Then go to P_ISSUE.
  - P_ISSUE: when no renderer request is granted, drive the RAM read and assert p_ack. Go to P_WAIT.
  - P_WAIT: assert p_rvalid with p_rdata=ram_rdata. Return to P_IDLE.
- Renderer read: r_ack is combinational and equals r_req whenever the renderer wins arbitration. r_rvalid/r_rdata follow one cycle after r_ack.
- FIFO pops (RAM writes) happen only in cycles not used by the renderer.
- ram_wdata and ram_addr are muxed combinationally from the granted source. ram_en=0 when idle.
- p_rdata and r_rdata are registered captures of ram_rdata, tagged by a 1-bit registered "last read owner".

## Timing
- Reset values:
  - p_ack=0, p_rvalid=0, r_ack=0, r_rvalid=0, ram_en=0, ram_we=0.
  - ram_addr=0, ram_wdata=0, p_rdata=0, r_rdata=0.
  - FIFO empty, pstate=P_IDLE, starvation counter=0.
- Renderer read latency: r_ack in cycle N, r_rvalid in N+1.
- Parser read latency with an empty FIFO and no renderer contention: request seen in N, P_DRAIN in N+1, p_ack in N+2, p_rvalid in N+3.
- Posted write: accepted in cycle N. Earliest RAM write in N+1.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits. Full/empty are decided by comparing the MSB (wrap) bit.
- Reset mid-operation:
  - FIFO contents are discarded and any in-flight read is dropped.
  - No rvalid is asserted after reset releases.
- r_req and a FIFO pop in the same cycle: the renderer wins and the FIFO head holds.

## Configuration
- TEXT_ARB_FAIRNESS_EN defined:
  - A counter increments every cycle a parser-side access (FIFO pop or P_ISSUE) is pending but loses to the renderer.
  - At STARVE_LIMIT, the next cycle grants the parser side and r_ack=0 even if r_req=1. The counter then clears.
  - The counter also clears on any parser-side grant.
- TEXT_ARB_FAIRNESS_EN undefined: strict renderer priority and no counter logic. A renderer holding r_req starves the parser indefinitely.

## Test plan
- Reset, then idle: all outputs 0. Renderer read addr 0x010 with ram_rdata=0xDEADBEEF: r_ack at N, r_rvalid with 0xDEADBEEF at N+1.
- Parser writes 0x001..0x004 back-to-back with r_req=0: four acks in consecutive cycles, RAM writes in order, data intact, FIFO empty after 5 cycles.
- Parser writes 5 entries while r_req=1 continuously (fairness off): first 4 acked, 5th held with p_ack=0, no RAM writes until r_req drops.
- Parser writes addr 0x020 = 0x55, then immediately reads 0x020: the read is issued only after the write completes, and p_rvalid returns the RAM data for 0x020.
- Fairness on, STARVE_LIMIT=8, r_req held 1, one posted write: write granted on the 9th cycle with r_ack=0 that cycle, then r_ack resumes.
- Assert rst while 3 FIFO entries are pending and a parser read is in P_WAIT: no further RAM writes and no p_rvalid after release.

Source files
------------

// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter: renderer-priority arbiter for the single-port text RAM with a posted parser write FIFO.
// Define TEXT_ARB_FAIRNESS_EN to force a parser-side grant after STARVE_LIMIT lost cycles.
module text_ram_arbiter #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic              p_ack,
   output logic              p_rvalid,
   output logic [DATA_W-1:0] p_rdata,
   input  logic              r_req,
   input  logic [ADDR_W-1:0] r_addr,
   output logic              r_ack,
   output logic              r_rvalid,
   output logic [DATA_W-1:0] r_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   localparam int IDX_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   typedef enum logic [1:0] {P_IDLE, P_DRAIN, P_ISSUE, P_WAIT} pstate_t;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_cfg_check
      $error("text_ram_arbiter: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
   end

   pstate_t           pstate_q, pstate_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_valid_q, rd_valid_d, owner_q, owner_d;
   logic [DATA_W-1:0] p_hold_q, p_hold_d, r_hold_q, r_hold_d;
   logic              fifo_empty, fifo_full, push, force_p, r_grant, w_grant, pr_grant;
   logic [IDX_W-1:0]  rd_idx;

   assign rd_idx     = rd_ptr_q[IDX_W-1:0];
   assign fifo_empty = wr_ptr_q == rd_ptr_q;
   assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                       (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

`ifdef TEXT_ARB_FAIRNESS_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             p_pending;

   assign p_pending = !fifo_empty || pstate_q == P_ISSUE;
   assign force_p   = p_pending && starve_q >= CNT_W'(STARVE_LIMIT);

   always_comb begin
      starve_d = (w_grant || pr_grant) ? '0 : (p_pending && r_grant) ? starve_q + 1'b1 : starve_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
   end
`else
   assign force_p = 1'b0;
`endif

   // Renderer first, then the FIFO head write, then a parser read once the FIFO has drained.
   assign r_grant  = r_req && !force_p;
   assign w_grant  = !r_grant && !fifo_empty;
   assign pr_grant = !r_grant && fifo_empty && pstate_q == P_ISSUE;
   assign push     = p_req && p_we && !fifo_full && pstate_q == P_IDLE;

   assign p_ack     = push || pr_grant;
   assign r_ack     = r_grant;
   assign ram_en    = r_grant || w_grant || pr_grant;
   assign ram_we    = w_grant;
   assign ram_addr  = r_grant ? r_addr : w_grant ? fifo_addr_q[rd_idx] : pr_grant ? rd_addr_q : '0;
   assign ram_wdata = w_grant ? fifo_data_q[rd_idx] : '0;
   assign p_rvalid  = rd_valid_q && owner_q;
   assign r_rvalid  = rd_valid_q && !owner_q;
   assign p_rdata   = p_rvalid ? ram_rdata : p_hold_q;
   assign r_rdata   = r_rvalid ? ram_rdata : r_hold_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      rd_ptr_d   = rd_ptr_q + PTR_W'(w_grant);
      rd_valid_d = r_grant || pr_grant;
      owner_d    = rd_valid_d ? pr_grant : owner_q;
      p_hold_d   = p_rvalid ? ram_rdata : p_hold_q;
      r_hold_d   = r_rvalid ? ram_rdata : r_hold_q;
      rd_addr_d  = (pstate_q == P_IDLE && p_req && !p_we) ? p_addr : rd_addr_q;
      pstate_d   = pstate_q;
      case (pstate_q)
         P_IDLE:  if (p_req && !p_we) pstate_d = P_DRAIN;
         P_DRAIN: if (fifo_empty) pstate_d = P_ISSUE;
         P_ISSUE: if (pr_grant) pstate_d = P_WAIT;
         default: pstate_d = P_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pstate_q   <= P_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_addr_q  <= '0;
         rd_valid_q <= 1'b0;
         owner_q    <= 1'b0;
         p_hold_q   <= '0;
         r_hold_q   <= '0;
      end else begin
         pstate_q   <= pstate_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_addr_q  <= rd_addr_d;
         rd_valid_q <= rd_valid_d;
         owner_q    <= owner_d;
         p_hold_q   <= p_hold_d;
         r_hold_q   <= r_hold_d;
      end
   end

   // Entry storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q[IDX_W-1:0]] <= p_addr;
         fifo_data_q[wr_ptr_q[IDX_W-1:0]] <= p_wdata;
      end
   end
endmodule

// File: tb/tb_text_ram_arbiter.sv
// tb_text_ram_arbiter: directed and randomized checks of text_ram_arbiter against a bench-side memory model.
module tb_text_ram_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p_req = 1'b0, p_we = 1'b0;
   logic [11:0] p_addr = '0;
   logic [31:0] p_wdata = '0;
   logic        p_ack, p_rvalid;
   logic [31:0] p_rdata;
   logic        r_req = 1'b0;
   logic [11:0] r_addr = '0;
   logic        r_ack, r_rvalid;
   logic [31:0] r_rdata;
   logic        ram_en, ram_we;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;

   int checks = 0;
   int fails = 0;

   logic [31:0] ram [4096];
   logic [31:0] exp_mem [4096];

   text_ram_arbiter dut (
      .clk(clk), .rst(rst),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_ack(p_ack), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
      .r_req(r_req), .r_addr(r_addr), .r_ack(r_ack), .r_rvalid(r_rvalid), .r_rdata(r_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] seed(int i);
      return (i == 16) ? 32'hDEADBEEF : 32'(i) * 32'h9E37_79B1 + 32'h0BAD_F00D;
   endfunction

   initial for (int i = 0; i < 4096; i++) ram[i] = seed(i);

   // Synchronous single-port RAM: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         else ram_rdata <= ram[ram_addr];
      end
   end

   task automatic idle;
      p_req = 1'b0; p_we = 1'b0; r_req = 1'b0;
   endtask

   task automatic test_reset;
      idle();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({p_ack, p_rvalid, r_ack, r_rvalid, ram_en, ram_we} !== 6'b0) begin
         fails++; $display("FAIL reset_flags: got %b expected 000000", {p_ack, p_rvalid, r_ack, r_rvalid, ram_en, ram_we});
      end
      checks++;
      if (ram_addr !== 12'h0 || ram_wdata !== 32'h0) begin
         fails++; $display("FAIL reset_ram_bus: got addr %h data %h expected 0 0", ram_addr, ram_wdata);
      end
      checks++;
      if (p_rdata !== 32'h0 || r_rdata !== 32'h0) begin
         fails++; $display("FAIL reset_rdata: got p %h r %h expected 0 0", p_rdata, r_rdata);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({p_ack, p_rvalid, r_ack, r_rvalid, ram_en, ram_we} !== 6'b0) begin
         fails++; $display("FAIL idle_after_reset: got %b expected 000000", {p_ack, p_rvalid, r_ack, r_rvalid, ram_en, ram_we});
      end
   endtask

   task automatic test_render_read;
      @(posedge clk); #1;
      r_req = 1'b1; r_addr = 12'h010;
      @(negedge clk);
      checks++;
      if (r_ack !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 12'h010 || r_rvalid !== 1'b0) begin
         fails++; $display("FAIL render_issue: got ack %b en %b we %b addr %h rvalid %b expected 1 1 0 010 0", r_ack, ram_en, ram_we, ram_addr, r_rvalid);
      end
      @(posedge clk); #1;
      r_req = 1'b0;
      @(negedge clk);
      checks++;
      if (r_rvalid !== 1'b1 || r_rdata !== 32'hDEADBEEF || p_rvalid !== 1'b0) begin
         fails++; $display("FAIL render_data: got rvalid %b data %h p_rvalid %b expected 1 deadbeef 0", r_rvalid, r_rdata, p_rvalid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (r_rvalid !== 1'b0 || r_rdata !== 32'hDEADBEEF) begin
         fails++; $display("FAIL render_hold: got rvalid %b data %h expected 0 deadbeef", r_rvalid, r_rdata);
      end
   endtask

   task automatic test_posted_writes;
      logic [31:0] d [4];
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         p_req = c < 4; p_we = 1'b1; p_addr = 12'(c + 1);
         if (c < 4) p_wdata = d[c];
         @(negedge clk);
         checks++;
         if (p_ack !== (c < 4)) begin
            fails++; $display("FAIL posted_ack c%0d: got %b expected %b", c, p_ack, c < 4);
         end
         checks++;
         if (c >= 1 && c <= 4) begin
            if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 12'(c) || ram_wdata !== d[c-1]) begin
               fails++; $display("FAIL posted_write c%0d: got en %b we %b addr %h data %h expected 1 1 %h %h", c, ram_en, ram_we, ram_addr, ram_wdata, 12'(c), d[c-1]);
            end
         end else if (ram_en !== 1'b0) begin
            fails++; $display("FAIL posted_idle c%0d: got ram_en %b expected 0", c, ram_en);
         end
         if (c < 4) exp_mem[c+1] = d[c];
      end
      idle();
   endtask

   task automatic test_full_hold;
      logic [31:0] d [5];
      int idx = 0;
      int wn = 0;
      for (int i = 0; i < 5; i++) d[i] = $urandom;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         r_req = 1'b1; r_addr = 12'h900;
         p_req = 1'b1; p_we = 1'b1; p_addr = 12'(12'h040 + idx); p_wdata = d[idx];
         @(negedge clk);
         checks++;
         if (p_ack !== (c < 4)) begin
            fails++; $display("FAIL full_ack c%0d: got %b expected %b", c, p_ack, c < 4);
         end
         checks++;
         if (ram_we !== 1'b0 || r_ack !== 1'b1) begin
            fails++; $display("FAIL full_starve c%0d: got we %b r_ack %b expected 0 1", c, ram_we, r_ack);
         end
         if (p_ack) idx++;
      end
      for (int c = 0; c < 20 && wn < 5; c++) begin
         @(posedge clk); #1;
         r_req = 1'b0;
         p_req = idx < 5;
         if (idx < 5) begin p_addr = 12'(12'h040 + idx); p_wdata = d[idx]; end
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (p_ack !== 1'b0 || ram_we !== 1'b1) begin
               fails++; $display("FAIL full_pop_push: got ack %b we %b expected 0 1", p_ack, ram_we);
            end
         end
         if (ram_we) begin
            checks++;
            if (ram_addr !== 12'(12'h040 + wn) || ram_wdata !== d[wn]) begin
               fails++; $display("FAIL full_order w%0d: got %h %h expected %h %h", wn, ram_addr, ram_wdata, 12'(12'h040 + wn), d[wn]);
            end
            exp_mem[12'h040 + wn] = d[wn];
            wn++;
         end
         if (p_ack && p_req) idx++;
      end
      checks++;
      if (wn != 5 || idx != 5) begin
         fails++; $display("FAIL full_drain: got writes %0d accepts %0d expected 5 5", wn, idx);
      end
      idle();
   endtask

   task automatic test_fairness;
      logic [31:0] d = $urandom;
      @(posedge clk); #1;
      r_req = 1'b1; r_addr = 12'h800;
      p_req = 1'b1; p_we = 1'b1; p_addr = 12'h050; p_wdata = d;
      @(negedge clk);
      checks++;
      if (p_ack !== 1'b1 || r_ack !== 1'b1) begin
         fails++; $display("FAIL fair_accept: got p_ack %b r_ack %b expected 1 1", p_ack, r_ack);
      end
      exp_mem[12'h050] = d;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         p_req = 1'b0;
         @(negedge clk);
         checks++;
         if (r_ack !== (c != 9) || ram_we !== (c == 9)) begin
            fails++; $display("FAIL fair_cycle%0d: got r_ack %b we %b expected %b %b", c, r_ack, ram_we, c != 9, c == 9);
         end
         if (c == 9) begin
            checks++;
            if (ram_addr !== 12'h050 || ram_wdata !== d) begin
               fails++; $display("FAIL fair_write: got %h %h expected 050 %h", ram_addr, ram_wdata, d);
            end
         end
      end
      idle();
   endtask

   task automatic test_raw;
      logic acked = 1'b0;
      logic wrote = 1'b0;
      @(posedge clk); #1;
      p_req = 1'b1; p_we = 1'b1; p_addr = 12'h020; p_wdata = 32'h55;
      @(negedge clk);
      checks++;
      if (p_ack !== 1'b1) begin
         fails++; $display("FAIL raw_write_ack: got %b expected 1", p_ack);
      end
      exp_mem[12'h020] = 32'h55;
      for (int c = 0; c < 20 && !acked; c++) begin
         @(posedge clk); #1;
         p_req = 1'b1; p_we = 1'b0; p_addr = 12'h020;
         @(negedge clk);
         if (ram_en && ram_we && ram_addr == 12'h020) wrote = 1'b1;
         if (p_ack) begin
            acked = 1'b1;
            checks++;
            if (!wrote || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 12'h020) begin
               fails++; $display("FAIL raw_order: got wrote %b en %b we %b addr %h expected 1 1 0 020", wrote, ram_en, ram_we, ram_addr);
            end
         end
      end
      @(posedge clk); #1;
      p_req = 1'b0;
      @(negedge clk);
      checks++;
      if (!acked || p_rvalid !== 1'b1 || p_rdata !== exp_mem[12'h020]) begin
         fails++; $display("FAIL raw_data: got acked %b rvalid %b data %h expected 1 1 %h", acked, p_rvalid, p_rdata, exp_mem[12'h020]);
      end
      idle();
   endtask

   task automatic test_read_latency;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         p_req = c < 3; p_we = 1'b0; p_addr = 12'h030;
         @(negedge clk);
         checks++;
         if (p_ack !== (c == 2) || p_rvalid !== (c == 3)) begin
            fails++; $display("FAIL rd_latency c%0d: got ack %b rvalid %b expected %b %b", c, p_ack, p_rvalid, c == 2, c == 3);
         end
         if (c == 2) begin
            checks++;
            if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 12'h030) begin
               fails++; $display("FAIL rd_issue: got en %b we %b addr %h expected 1 0 030", ram_en, ram_we, ram_addr);
            end
         end
         if (c >= 3) begin
            checks++;
            if (p_rdata !== exp_mem[12'h030]) begin
               fails++; $display("FAIL rd_data c%0d: got %h expected %h", c, p_rdata, exp_mem[12'h030]);
            end
         end
      end
      idle();
   endtask

   task automatic test_reset_mid;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         r_req = 1'b1; r_addr = 12'h800;
         p_req = 1'b1; p_we = 1'b1; p_addr = 12'(12'h060 + c); p_wdata = $urandom;
         @(negedge clk);
         checks++;
         if (p_ack !== 1'b1) begin
            fails++; $display("FAIL rstmid_push c%0d: got %b expected 1", c, p_ack);
         end
      end
      idle();
      rst = 1'b1;
      #1;
      checks++;
      if (ram_en !== 1'b0 || p_ack !== 1'b0) begin
         fails++; $display("FAIL rstmid_async: got en %b ack %b expected 0 0", ram_en, p_ack);
      end
      @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (ram_en !== 1'b0 || p_rvalid !== 1'b0 || r_rvalid !== 1'b0) begin
            fails++; $display("FAIL rstmid_fifo c%0d: got en %b prv %b rrv %b expected 0 0 0", c, ram_en, p_rvalid, r_rvalid);
         end
         @(posedge clk); #1;
      end
      for (int c = 0; c < 4; c++) begin
         p_req = c < 3; p_we = 1'b0; p_addr = 12'h070;
         @(negedge clk);
         if (c == 3) begin
            checks++;
            if (p_rvalid !== 1'b1) begin
               fails++; $display("FAIL rstmid_wait: got rvalid %b expected 1", p_rvalid);
            end
         end
         if (c < 3) begin @(posedge clk); #1; end
      end
      idle();
      rst = 1'b1;
      #1;
      checks++;
      if (p_rvalid !== 1'b0) begin
         fails++; $display("FAIL rstmid_drop: got rvalid %b expected 0", p_rvalid);
      end
      @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (ram_en !== 1'b0 || p_rvalid !== 1'b0 || r_rvalid !== 1'b0) begin
            fails++; $display("FAIL rstmid_read c%0d: got en %b prv %b rrv %b expected 0 0 0", c, ram_en, p_rvalid, r_rvalid);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random;
      logic        busy = 1'b0, cur_we = 1'b0, rd_pend = 1'b0;
      logic [11:0] cur_a = '0, a;
      logic [31:0] cur_d = '0, rd_exp = '0;
      int          wait_cnt = 0;
      logic [11:0] wq_a [$];
      logic [31:0] wq_d [$];
      logic [11:0] rq [$];
      for (int c = 0; c < 420; c++) begin
         @(posedge clk); #1;
         if (!busy && c < 400 && $urandom_range(0, 2) != 0) begin
            busy = 1'b1; cur_we = 1'($urandom_range(0, 1));
            cur_a = 12'($urandom_range(0, 255)); cur_d = $urandom; wait_cnt = 0;
         end
         p_req = busy; p_we = cur_we; p_addr = cur_a; p_wdata = cur_d;
         r_req = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
         r_addr = 12'(12'h800 + $urandom_range(0, 2047));
         @(negedge clk);
         checks++;
`ifdef TEXT_ARB_FAIRNESS_EN
         if (r_ack && !r_req) begin
`else
         if (r_ack !== r_req) begin
`endif
            fails++; $display("FAIL rnd_r_ack c%0d: got %b with r_req %b", c, r_ack, r_req);
         end
         if (r_ack) begin
            checks++;
            if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== r_addr) begin
               fails++; $display("FAIL rnd_r_issue c%0d: got en %b we %b addr %h expected 1 0 %h", c, ram_en, ram_we, ram_addr, r_addr);
            end
            rq.push_back(r_addr);
         end
         if (r_rvalid) begin
            checks++;
            if (rq.size() < 2 && !(rq.size() == 1 && !r_ack)) begin
               fails++; $display("FAIL rnd_r_spurious c%0d: got r_rvalid 1 expected 0", c);
            end else begin
               a = rq.pop_front();
               if (r_rdata !== exp_mem[a]) begin
                  fails++; $display("FAIL rnd_r_data c%0d: got %h expected %h", c, r_rdata, exp_mem[a]);
               end
            end
         end
         checks++;
         if (p_rvalid !== rd_pend || (rd_pend && p_rdata !== rd_exp)) begin
            fails++; $display("FAIL rnd_p_rdata c%0d: got rvalid %b data %h expected %b %h", c, p_rvalid, p_rdata, rd_pend, rd_exp);
         end
         rd_pend = 1'b0;
         if (ram_en && ram_we) begin
            checks++;
            if (wq_a.size() == 0) begin
               fails++; $display("FAIL rnd_w_spurious c%0d: got write %h expected none", c, ram_addr);
            end else begin
               if (ram_addr !== wq_a[0] || ram_wdata !== wq_d[0]) begin
                  fails++; $display("FAIL rnd_w_order c%0d: got %h %h expected %h %h", c, ram_addr, ram_wdata, wq_a[0], wq_d[0]);
               end
               void'(wq_a.pop_front()); void'(wq_d.pop_front());
            end
         end
         if (busy && p_ack) begin
            if (cur_we) begin
               exp_mem[cur_a] = cur_d;
               wq_a.push_back(cur_a); wq_d.push_back(cur_d);
            end else begin
               checks++;
               if (wq_a.size() != 0 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== cur_a) begin
                  fails++; $display("FAIL rnd_p_issue c%0d: got pending %0d en %b we %b addr %h expected 0 1 0 %h", c, wq_a.size(), ram_en, ram_we, ram_addr, cur_a);
               end
               rd_pend = 1'b1; rd_exp = exp_mem[cur_a];
            end
            busy = 1'b0;
         end else if (busy && ++wait_cnt > 100) begin
            checks++; fails++;
            $display("FAIL rnd_p_timeout c%0d: got no p_ack in 100 cycles expected an ack", c);
            busy = 1'b0;
         end
      end
      checks++;
      if (busy || wq_a.size() != 0 || rq.size() != 0) begin
         fails++; $display("FAIL rnd_drain: got busy %b writes %0d reads %0d expected 0 0 0", busy, wq_a.size(), rq.size());
      end
      idle();
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) exp_mem[i] = seed(i);
      test_reset();
      test_render_read();
      test_posted_writes();
`ifdef TEXT_ARB_FAIRNESS_EN
      test_fairness();
`else
      test_full_hold();
`endif
      test_raw();
      test_read_latency();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000 ns expected end of test");
      $fatal(1, "watchdog");
   end
endmodule
